alu_result_packer: RTL

- Downstream consumer of the registered 8-bit ALU output stage.
- Collects the per-cycle result byte and zero flag, packs PACK consecutive bytes into one word, and buffers words in a small FIFO.
- The FIFO drains through a valid/ready interface toward the bus/writeback side.
- Also keeps a saturating count of zero results and a sticky overflow flag.

---
 rtl/alu_result_packer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_packer.sv
// alu_result_packer
// Packs consecutive ALU result bytes into PACK-byte words and queues them in a
// small show-ahead FIFO. The FIFO drains through a valid/ready interface.
// Also keeps a saturating count of zero results and a sticky overflow flag that
// is set when a completed word is dropped because the FIFO is full.
module alu_result_packer #(
  parameter int DATA_W     = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*PACK-1:0]   out_data,
  output logic [$clog2(PACK):0]    out_bytes,
  output logic [CNT_W-1:0]         zero_count,
  output logic                     overflow
);

  localparam int LW     = $clog2(PACK);
  localparam int BW     = LW + 1;
  localparam int WORD_W = DATA_W * PACK;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int OW     = PW + 1;

  // Pack register and lane index
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [LW-1:0]     lane_q, lane_d;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0] mem_data_q  [FIFO_DEPTH];
  logic [BW-1:0]     mem_bytes_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;

  // Registered head view presented on the output port
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [BW-1:0]     out_bytes_q, out_bytes_d;

  // Statistics
  logic [CNT_W-1:0]  zero_count_q, zero_count_d;
  logic              overflow_q, overflow_d;

  // Word as it looks with this cycle's byte merged in
  logic [WORD_W-1:0] word_in;
  logic              full_word;
  logic              flush_emit;
  logic              push_req;
  logic [BW-1:0]     push_bytes;
  logic              pop;
  logic              fifo_full;
  logic              push_ok;
  logic              drop;
  logic [PW-1:0]     rd_next;

  // Merge the incoming byte into its lane; other lanes keep the pack register
  // contents, which are zero beyond the current lane.
  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      assign word_in[gi*DATA_W +: DATA_W] =
        (in_valid && (lane_q == LW'(gi))) ? in_result : pack_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Decide whether a word is emitted this cycle and whether the FIFO takes it
  always_comb begin
    full_word  = in_valid && (lane_q == LW'(PACK - 1));
    flush_emit = flush && ((lane_q != '0) || in_valid);
    push_req   = full_word || flush_emit;
    push_bytes = full_word ? BW'(PACK) : (BW'(lane_q) + BW'(in_valid));
    pop        = out_valid_q && out_ready;
    fifo_full  = (occ_q == OW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok    = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    rd_next    = rd_ptr_q + PW'(1);
  end

  // Pack register: clears on every emit (even a dropped one), else fills a lane
  always_comb begin
    pack_d = pack_q;
    lane_d = lane_q;
    if (push_req) begin
      pack_d = '0;
      lane_d = '0;
    end else if (in_valid) begin
      pack_d = word_in;
      lane_d = lane_q + LW'(1);
    end
  end

  // FIFO pointers, occupancy and the registered show-ahead head
  always_comb begin
    wr_ptr_d    = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_next : rd_ptr_q;
    occ_d       = occ_q + OW'(push_ok) - OW'(pop);
    out_valid_d = (occ_d != '0);
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    if (occ_d != '0) begin
      if ((occ_q == '0) || (pop && (occ_q == OW'(1)))) begin
        // FIFO empties apart from the word pushed now: it becomes the head.
        out_data_d  = word_in;
        out_bytes_d = push_bytes;
      end else if (pop) begin
        out_data_d  = mem_data_q[rd_next];
        out_bytes_d = mem_bytes_q[rd_next];
      end else begin
        out_data_d  = mem_data_q[rd_ptr_q];
        out_bytes_d = mem_bytes_q[rd_ptr_q];
      end
    end
  end

  // Zero-result counter saturates; overflow is sticky until reset
  always_comb begin
    zero_count_d = zero_count_q;
    if (in_valid && in_zero && (zero_count_q != {CNT_W{1'b1}})) begin
      zero_count_d = zero_count_q + CNT_W'(1);
    end
    overflow_d = overflow_q | drop;
  end

  // FIFO storage write; contents need no reset because pointers gate them
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_data_q[wr_ptr_q]  <= word_in;
      mem_bytes_q[wr_ptr_q] <= push_bytes;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pack_q       <= '0;
      lane_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bytes_q  <= '0;
      zero_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pack_q       <= pack_d;
      lane_q       <= lane_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bytes_q  <= out_bytes_d;
      zero_count_q <= zero_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_bytes  = out_bytes_q;
  assign zero_count = zero_count_q;
  assign overflow   = overflow_q;

endmodule
